// File: rtl/imem_loader_if.sv
// imem_loader bundle: byte stream in, instruction memory port out.
// master = upstream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] addr_ext;
  logic              wen_ext;
  logic              ren_ext;
  logic [31:0]       wdata_ext;

  modport master (
    output s_valid, s_data,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs LE bytes into words, writes imem,
// verifies a trailing XOR byte, then releases the cpu.
module imem_loader #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 512
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         start,
  input  logic [15:0]  word_count,
  imem_loader_if.slave bus,
  output logic         cpu_enable,
  output logic         busy,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, CHECK, RUN, ERROR
  } state_t;

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_cnt;
  logic [15:0]       r_widx;
  logic [1:0]        r_byte;
  logic [7:0]        r_csum;
  logic [23:0]       r_asm;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              w_start;
  logic              w_recv_xfer;
  logic [15:0]       w_widx_nx;

  assign w_start = start & ((r_state == IDLE) |
                            (r_state == RUN)  |
                            (r_state == ERROR));
  assign w_recv_xfer = bus.s_valid & (r_state == RECV);
  assign w_widx_nx   = r_widx + 16'd1;

  assign bus.addr_ext  = r_addr;
  assign bus.wdata_ext = r_wdata;
  assign bus.ren_ext   = 1'b0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.s_ready = 1'b0;
    bus.wen_ext = 1'b0;
    cpu_enable  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    unique case (r_state)
      IDLE: ;
      RECV: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
        if (bus.s_valid && r_byte == 2'd3) w_next = WRITE;
      end
      WRITE: begin
        bus.wen_ext = 1'b1;
        busy        = 1'b1;
        w_next      = (w_widx_nx == r_cnt) ? CHECK : RECV;
      end
      CHECK: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
        if (bus.s_valid)
          w_next = (bus.s_data == r_csum) ? RUN : ERROR;
      end
      RUN: begin
        cpu_enable = 1'b1;
        done       = 1'b1;
      end
      ERROR: error = 1'b1;
      default: w_next = IDLE;
    endcase
    if (w_start) begin
      if ({1'b0, word_count} > MAXW) w_next = ERROR;
      else if (word_count == 16'd0)  w_next = CHECK;
      else                           w_next = RECV;
    end
  end

  // wdata only changes on the 4th byte so it holds outside WRITE
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt   <= '0;
      r_widx  <= '0;
      r_byte  <= '0;
      r_csum  <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
    end else if (w_start) begin
      r_cnt  <= word_count;
      r_widx <= '0;
      r_byte <= '0;
      r_csum <= '0;
      r_addr <= BASE_ADDR;
    end else if (w_recv_xfer) begin
      r_byte <= r_byte + 2'd1;
      r_csum <= r_csum ^ bus.s_data;
      unique case (r_byte)
        2'd0: r_asm[7:0]   <= bus.s_data;
        2'd1: r_asm[15:8]  <= bus.s_data;
        2'd2: r_asm[23:16] <= bus.s_data;
        default: r_wdata   <= {bus.s_data, r_asm};
      endcase
    end else if (r_state == WRITE) begin
      r_widx <= w_widx_nx;
      r_addr <= r_addr + ADDR_W'(4);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, reset abort,
// and randomized loads against a queue-based model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_count = '0;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader_if #(.ADDR_W(64)) bus();

  imem_loader #(
    .ADDR_W(64),
    .BASE_ADDR(64'h0),
    .MAX_WORDS(512)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .start(start),
    .word_count(word_count),
    .bus(bus),
    .cpu_enable(cpu_enable),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  logic [63:0] cap_a[$];
  logic [31:0] cap_d[$];
  int          n_hs  = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (bus.wen_ext) begin
      cap_a.push_back(bus.addr_ext);
      cap_d.push_back(bus.wdata_ext);
    end
    if (bus.s_valid && bus.s_ready) n_hs++;
    if (bus.wen_ext && bus.s_ready) n_bad++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps)
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        @(posedge clk); #1;
      end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL byte_timeout: got no s_ready for byte %0h", b);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run_load(input int wc, input logic [7:0] q[$],
                          input logic [7:0] cs, input bit gaps,
                          input string tag, output int wb);
    logic [7:0]  x;
    bit          ok;
    int          nw;
    int          hb;
    int          bb;
    int          rdy;
    logic [31:0] ed;
    wb = cap_d.size();
    hb = n_hs;
    bb = n_bad;
    // model: words are LE groups of 4, checksum is XOR of payload
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    nw = (wc > 512) ? 0 : wc;
    ok = (wc <= 512) && (x == cs);
    start = 1'b1;
    word_count = wc[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " en_drop"}, 64'(cpu_enable), 64'd0);
    if (wc > 512) begin
      chk({tag, " err_next"}, 64'(error), 64'd1);
      rdy = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.s_ready) rdy++;
      end
      chk({tag, " no_ready"}, 64'(rdy), 64'd0);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < 4 * wc; i++) send_byte(q[i], gaps);
      send_byte(cs, gaps);
      repeat (2) @(posedge clk);
      #1;
    end
    chk({tag, " n_wr"}, 64'(cap_d.size() - wb), 64'(nw));
    for (int i = 0; i < nw && wb + i < cap_d.size(); i++) begin
      ed = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
      chk($sformatf("%s addr%0d", tag, i), cap_a[wb+i], 64'(4 * i));
      chk($sformatf("%s data%0d", tag, i), 64'(cap_d[wb+i]), 64'(ed));
    end
    chk({tag, " done"}, 64'(done), 64'(ok));
    chk({tag, " en"}, 64'(cpu_enable), 64'(ok));
    chk({tag, " err"}, 64'(error), 64'(!ok));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " n_bytes"}, 64'(n_hs - hb),
        64'((wc > 512) ? 0 : 4 * wc + 1));
    chk({tag, " rdy_in_wr"}, 64'(n_bad - bb), 64'd0);
  endtask

  typedef struct {
    int          wc;
    logic [63:0] b;
    logic [7:0]  cs;
    bit          gaps;
    int          ewr;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          edone;
    bit          eerr;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  q[$];
  int          wb;
  int          wc;
  logic [7:0]  xs;
  logic [7:0]  cs;

  task automatic check_idle_outputs(input string tag);
    chk({tag, " s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, " addr"}, bus.addr_ext, 64'd0);
    chk({tag, " wen"}, 64'(bus.wen_ext), 64'd0);
    chk({tag, " ren"}, 64'(bus.ren_ext), 64'd0);
    chk({tag, " wdata"}, 64'(bus.wdata_ext), 64'd0);
    chk({tag, " cpu_en"}, 64'(cpu_enable), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    tbl[0] = '{2, 64'h00a0011300500093, 8'h71, 1'b0, 2,
               32'h00500093, 32'h00a00113, 1'b1, 1'b0};
    tbl[1] = '{2, 64'h00a0011300500093, 8'h70, 1'b0, 2,
               32'h00500093, 32'h00a00113, 1'b0, 1'b1};
    tbl[2] = '{0, 64'h0, 8'h00, 1'b0, 0,
               32'h0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{513, 64'h0, 8'h00, 1'b0, 0,
               32'h0, 32'h0, 1'b0, 1'b1};
    tbl[4] = '{2, 64'h00a0011300500093, 8'h71, 1'b1, 2,
               32'h00500093, 32'h00a00113, 1'b1, 1'b0};
    tbl[5] = '{1, 64'h0000000000000013, 8'h13, 1'b0, 1,
               32'h00000013, 32'h0, 1'b1, 1'b0};

    #1;
    check_idle_outputs("reset");
    #11 arst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int k = 0; k < 4 * tbl[i].wc && k < 8; k++)
        q.push_back(tbl[i].b[8*k +: 8]);
      run_load(tbl[i].wc, q, tbl[i].cs, tbl[i].gaps,
               $sformatf("tbl%0d", i), wb);
      chk($sformatf("tbl%0d exp_nwr", i),
          64'(cap_d.size() - wb), 64'(tbl[i].ewr));
      if (tbl[i].ewr > 0 && cap_d.size() > wb)
        chk($sformatf("tbl%0d exp_d0", i),
            64'(cap_d[wb]), 64'(tbl[i].d0));
      if (tbl[i].ewr > 1 && cap_d.size() > wb + 1)
        chk($sformatf("tbl%0d exp_d1", i),
            64'(cap_d[wb+1]), 64'(tbl[i].d1));
      chk($sformatf("tbl%0d exp_done", i), 64'(done),
          64'(tbl[i].edone));
      chk($sformatf("tbl%0d exp_err", i), 64'(error),
          64'(tbl[i].eerr));
    end

    // abort a load after the 6th byte with an async reset
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(tbl[0].b[8*k +: 8]);
    start = 1'b1;
    word_count = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) send_byte(q[k], 1'b0);
    chk("mid busy", 64'(busy), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    run_load(2, q, 8'h71, 1'b0, "after_rst", wb);

    for (int r = 0; r < 20; r++) begin
      wc = $urandom_range(0, 4);
      q.delete();
      xs = 8'h00;
      for (int k = 0; k < 4 * wc; k++) begin
        q.push_back(8'($urandom));
        xs = xs ^ q[k];
      end
      cs = ($urandom_range(0, 3) == 0) ?
           xs ^ 8'($urandom_range(1, 255)) : xs;
      run_load(wc, q, cs, 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", r), wb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
